// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings for the UART transmit controller
// State codes, parity polarity constants and TX output mux selects.
package uart_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [1:0] {
    SEL_START  = 2'd0,
    SEL_DATA   = 2'd1,
    SEL_PARITY = 2'd2,
    SEL_STOP   = 2'd3
  } tx_sel_t;

  // word_xor is the XOR reduction of the payload; odd parity inverts it
  function automatic logic parity_bit(input logic word_xor, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~word_xor : word_xor;
  endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// rtl/uart_tx_shift.sv - payload shift register and bit counter for the UART TX
// bit_out presents the next bit to send; done flags the last payload bit.
module uart_tx_shift #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift_en,
  input  logic                  cnt_en,
  output logic                  bit_out,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sreg;
  logic [CNT_W-1:0]      cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= '0;
    end else begin
      if (shift_en) sreg <= {1'b0, sreg[DATA_WIDTH-1:1]};
      if (cnt_en)   cnt  <= cnt + CNT_W'(1);
    end
  end

  assign bit_out = sreg[0];
  assign done    = (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit controller: FSM, parity and output mux
// Define UART_TX_BUF_EN to add a one-entry holding buffer for gapless back-to-back frames.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VLD,
  output logic                  DATA_RDY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  state_t                state, next_state;
  tx_sel_t               tx_sel;
  logic                  tx_next;
  logic                  xfer, frame_load;
  logic [DATA_WIDTH-1:0] data_q, src_data;
  logic                  par_en_q, par_typ_q, stop2_q;
  logic                  src_par_en, src_par_typ, src_stop2;
  logic                  shift_bit, shift_done;

  assign xfer = DATA_VLD && DATA_RDY;

`ifdef UART_TX_BUF_EN
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_par_en, buf_par_typ, buf_stop2, buf_full;
  logic                  last_stop, load_from_buf, load_direct, buf_fill;

  assign last_stop     = (state == S_STOP1 && !stop2_q) || (state == S_STOP2);
  assign load_from_buf = last_stop && buf_full;
  assign load_direct   = xfer && ((state == S_IDLE) || (last_stop && !buf_full));
  assign buf_fill      = xfer && !load_direct;
  assign frame_load    = load_from_buf || load_direct;
  assign DATA_RDY      = !buf_full;

  assign src_data    = load_from_buf ? buf_data    : P_DATA;
  assign src_par_en  = load_from_buf ? buf_par_en  : PAR_EN;
  assign src_par_typ = load_from_buf ? buf_par_typ : PAR_TYP;
  assign src_stop2   = load_from_buf ? buf_stop2   : STOP2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      buf_full    <= 1'b0;
      buf_data    <= '0;
      buf_par_en  <= 1'b0;
      buf_par_typ <= 1'b0;
      buf_stop2   <= 1'b0;
    end else if (load_from_buf) begin
      buf_full <= 1'b0;
    end else if (buf_fill) begin
      buf_full    <= 1'b1;
      buf_data    <= P_DATA;
      buf_par_en  <= PAR_EN;
      buf_par_typ <= PAR_TYP;
      buf_stop2   <= STOP2;
    end
  end
`else
  assign DATA_RDY    = (state == S_IDLE);
  assign frame_load  = xfer;
  assign src_data    = P_DATA;
  assign src_par_en  = PAR_EN;
  assign src_par_typ = PAR_TYP;
  assign src_stop2   = STOP2;
`endif

  // Frame configuration is frozen at load so pin changes mid-frame are harmless
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (frame_load) begin
      data_q    <= src_data;
      par_en_q  <= src_par_en;
      par_typ_q <= src_par_typ;
      stop2_q   <= src_stop2;
    end
  end

  uart_tx_shift #(.DATA_WIDTH(DATA_WIDTH)) u_shift (
    .CLK       (CLK),
    .RST       (RST),
    .load      (frame_load),
    .load_data (src_data),
    .shift_en  (next_state == S_DATA),
    .cnt_en    (state == S_DATA),
    .bit_out   (shift_bit),
    .done      (shift_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      TX_OUT <= 1'b1;
      BUSY   <= 1'b0;
    end else begin
      state  <= next_state;
      TX_OUT <= tx_next;
      BUSY   <= (next_state != S_IDLE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (frame_load) next_state = S_START;
      S_START:  next_state = S_DATA;
      S_DATA:   if (shift_done) next_state = par_en_q ? S_PARITY : S_STOP1;
      S_PARITY: next_state = S_STOP1;
      S_STOP1:  next_state = stop2_q ? S_STOP2 : (frame_load ? S_START : S_IDLE);
      S_STOP2:  next_state = frame_load ? S_START : S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // The line register is loaded with the level belonging to the state being entered
  always_comb begin
    tx_sel = SEL_STOP;
    case (next_state)
      S_START:  tx_sel = SEL_START;
      S_DATA:   tx_sel = SEL_DATA;
      S_PARITY: tx_sel = SEL_PARITY;
      default:  tx_sel = SEL_STOP;
    endcase
    tx_next = 1'b1;
    case (tx_sel)
      SEL_START:  tx_next = 1'b0;
      SEL_DATA:   tx_next = shift_bit;
      SEL_PARITY: tx_next = parity_bit(^data_q, par_typ_q);
      default:    tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl
// Frames are captured one line bit per cycle, first bit in the MSB of a 24-bit word.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic [4:0] P_DATA5;
  logic       DATA_VLD, DATA_VLD5, PAR_EN, PAR_TYP, STOP2;
  logic       DATA_RDY, TX_OUT, BUSY;
  logic       DATA_RDY5, TX5, BUSY5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VLD(DATA_VLD), .DATA_RDY(DATA_RDY),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .TX_OUT(TX_OUT), .BUSY(BUSY)
  );

  uart_tx_ctrl #(.DATA_WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA5), .DATA_VLD(DATA_VLD5), .DATA_RDY(DATA_RDY5),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .TX_OUT(TX5), .BUSY(BUSY5)
  );

  task automatic run_frame(input bit use5, input logic [7:0] d, input logic pe, input logic pt,
                           input logic s2, input int ev_at, input logic [7:0] ev_d,
                           input logic ev_v, input logic ev_pt, input logic ev_s2,
                           output logic [23:0] obs, output int busy_n, output logic rdy_ev);
    PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
    if (use5) begin P_DATA5 = d[4:0]; DATA_VLD5 = 1'b1; end
    else begin P_DATA = d; DATA_VLD = 1'b1; end
    @(posedge CLK); #1;
    DATA_VLD = 1'b0; DATA_VLD5 = 1'b0;
    obs = '0; busy_n = 0; rdy_ev = 1'b1;
    for (int i = 0; i < 24; i++) begin
      obs = {obs[22:0], use5 ? TX5 : TX_OUT};
      if (use5 ? BUSY5 : BUSY) busy_n++;
      if (i == ev_at) begin
        rdy_ev = DATA_RDY; P_DATA = ev_d; DATA_VLD = ev_v; PAR_TYP = ev_pt; STOP2 = ev_s2;
      end
      @(posedge CLK); #1;
      DATA_VLD = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; DATA_VLD = 0; DATA_VLD5 = 0; P_DATA = 0; P_DATA5 = 0;
    PAR_EN = 0; PAR_TYP = 0; STOP2 = 0;
    repeat (2) @(posedge CLK); #1;
    n_cmp++; if (TX_OUT !== 1'b1)   begin n_bad++; $display("FAIL reset_tx: got %b want 1", TX_OUT); end
    n_cmp++; if (BUSY !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_cmp++; if (DATA_RDY !== 1'b1) begin n_bad++; $display("FAIL reset_rdy: got %b want 1", DATA_RDY); end
    n_cmp++; if ({TX5, BUSY5, DATA_RDY5} !== 3'b101) begin n_bad++; $display("FAIL reset_w5: got %b want 101", {TX5, BUSY5, DATA_RDY5}); end
    RST = 1'b1;
    @(posedge CLK); #1;
    n_cmp++; if ({TX_OUT, BUSY} !== 2'b10) begin n_bad++; $display("FAIL idle_after_reset: got %b want 10", {TX_OUT, BUSY}); end
  endtask

  task automatic test_even_parity();
    logic [23:0] obs; int bn; logic r;
    run_frame(0, 8'hA5, 1, 0, 0, -1, 8'h00, 0, 0, 0, obs, bn, r);
    n_cmp++; if (obs !== 24'b01010010101_1111111111111) begin n_bad++; $display("FAIL even_par_tx: got %b want %b", obs, 24'b01010010101_1111111111111); end
    n_cmp++; if (bn !== 11) begin n_bad++; $display("FAIL even_par_busy: got %0d want 11", bn); end
  endtask

  task automatic test_odd_parity_stop2();
    logic [23:0] obs; int bn; logic r;
    run_frame(0, 8'h01, 1, 1, 1, -1, 8'h00, 0, 1, 1, obs, bn, r);
    n_cmp++; if (obs !== 24'b010000000011_111111111111) begin n_bad++; $display("FAIL odd_stop2_tx: got %b want %b", obs, 24'b010000000011_111111111111); end
    n_cmp++; if (bn !== 12) begin n_bad++; $display("FAIL odd_stop2_busy: got %0d want 12", bn); end
  endtask

  task automatic test_no_parity();
    logic [23:0] obs; int bn; logic r;
    run_frame(0, 8'hFF, 0, 0, 0, -1, 8'h00, 0, 0, 0, obs, bn, r);
    n_cmp++; if (obs !== 24'b0111_1111_1111_1111_1111_1111) begin n_bad++; $display("FAIL nopar_tx: got %b want %b", obs, 24'b0111_1111_1111_1111_1111_1111); end
    n_cmp++; if (bn !== 10) begin n_bad++; $display("FAIL nopar_busy: got %0d want 10", bn); end
    run_frame(1, 8'h16, 0, 0, 0, -1, 8'h00, 0, 0, 0, obs, bn, r);
    n_cmp++; if (obs !== 24'b0011011_11111111111111111) begin n_bad++; $display("FAIL w5_tx: got %b want %b", obs, 24'b0011011_11111111111111111); end
    n_cmp++; if (bn !== 7) begin n_bad++; $display("FAIL w5_busy: got %0d want 7", bn); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] obs; int bn; logic r;
    run_frame(0, 8'hA5, 1, 0, 0, 3, 8'h01, 1, 0, 0, obs, bn, r);
`ifdef UART_TX_BUF_EN
    n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy: got %b want 1", r); end
    n_cmp++; if (obs !== 24'b01010010101_01000000011_11) begin n_bad++; $display("FAIL b2b_tx: got %b want %b", obs, 24'b01010010101_01000000011_11); end
    n_cmp++; if (bn !== 22) begin n_bad++; $display("FAIL b2b_busy: got %0d want 22", bn); end
`else
    n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL drop_rdy: got %b want 0", r); end
    n_cmp++; if (obs !== 24'b01010010101_1111111111111) begin n_bad++; $display("FAIL drop_tx: got %b want %b", obs, 24'b01010010101_1111111111111); end
    n_cmp++; if (bn !== 11) begin n_bad++; $display("FAIL drop_busy: got %0d want 11", bn); end
`endif
    n_cmp++; if (DATA_RDY !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy_end: got %b want 1", DATA_RDY); end
  endtask

  task automatic test_reset_mid_frame();
    logic [23:0] obs; int bn; logic r;
    PAR_EN = 1; PAR_TYP = 0; STOP2 = 0; P_DATA = 8'hA5; DATA_VLD = 1'b1;
    @(posedge CLK); #1;
    DATA_VLD = 1'b0;
    repeat (4) begin @(posedge CLK); #1; end
    n_cmp++; if ({TX_OUT, BUSY} !== 2'b01) begin n_bad++; $display("FAIL bit3_before_reset: got %b want 01", {TX_OUT, BUSY}); end
    #2 RST = 1'b0;
    #1;
    n_cmp++; if (TX_OUT !== 1'b1)   begin n_bad++; $display("FAIL midreset_tx: got %b want 1", TX_OUT); end
    n_cmp++; if (BUSY !== 1'b0)     begin n_bad++; $display("FAIL midreset_busy: got %b want 0", BUSY); end
    n_cmp++; if (DATA_RDY !== 1'b1) begin n_bad++; $display("FAIL midreset_rdy: got %b want 1", DATA_RDY); end
    @(posedge CLK); #1;
    RST = 1'b1;
    run_frame(0, 8'h3C, 1, 0, 0, -1, 8'h00, 0, 0, 0, obs, bn, r);
    n_cmp++; if (obs !== 24'b00011110001_1111111111111) begin n_bad++; $display("FAIL post_reset_tx: got %b want %b", obs, 24'b00011110001_1111111111111); end
    n_cmp++; if (bn !== 11) begin n_bad++; $display("FAIL post_reset_busy: got %0d want 11", bn); end
  endtask

  task automatic test_config_latch();
    logic [23:0] obs; int bn; logic r;
    run_frame(0, 8'hA5, 1, 0, 0, 3, 8'hA5, 0, 1, 1, obs, bn, r);
    n_cmp++; if (obs !== 24'b01010010101_1111111111111) begin n_bad++; $display("FAIL latch_cur_tx: got %b want %b", obs, 24'b01010010101_1111111111111); end
    n_cmp++; if (bn !== 11) begin n_bad++; $display("FAIL latch_cur_busy: got %0d want 11", bn); end
    run_frame(0, 8'hA5, 1, 1, 1, -1, 8'h00, 0, 1, 1, obs, bn, r);
    n_cmp++; if (obs !== 24'b010100101111_111111111111) begin n_bad++; $display("FAIL latch_next_tx: got %b want %b", obs, 24'b010100101111_111111111111); end
    n_cmp++; if (bn !== 12) begin n_bad++; $display("FAIL latch_next_busy: got %0d want 12", bn); end
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_odd_parity_stop2();
    test_no_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_config_latch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
